game_session_fsm: RTL and testbench
===================================

GAME_SESSION_FSM -- requirements
Module: game_session_fsm

Interface
REQ-001 SHALL have parameter NUM_OPPONENTS, default 1, number of networked opponents, legal range 1..4.
REQ-002 SHALL have parameter SPRINT_LINES, default 40, lines-cleared target that wins sprint mode.
REQ-003 SHALL have parameter LINES_W, default 6, width of lines_cleared; SPRINT_LINES < 2**LINES_W.
REQ-004 SHALL have parameter COUNTDOWN_CYCLES, default 4, pre-game countdown length in clocks, >= 1.
REQ-005 SHALL have parameter RESULT_HOLD_CYCLES, default 8, clocks the result screen ignores exit inputs, >= 1.
REQ-006 SHALL have ports: clk input 1 system clock; rst_l input 1 asynchronous active-low reset.
REQ-007 SHALL have ports: start_sprint, battle_ready, ready_withdraw, pause_toggle input 1 each, local player requests, single-cycle pulses.
REQ-008 SHALL have ports: top_out input 1 local top-out pulse; lines_cleared input LINES_W local line count.
REQ-009 SHALL have ports: opponent_ready, opponent_lost input NUM_OPPONENTS each, per-opponent level/pulse.
REQ-010 SHALL have ports: current_screen output 3 state code; game_start, game_end output 1 pulses; game_won output 1.
REQ-011 SHALL have ports: opponents_alive output 3 live opponent count; countdown_value output $clog2(COUNTDOWN_CYCLES+1) remaining clocks; randomizer_race output 1.

Function
REQ-012 SHALL encode states START=0, MP_READY=1, COUNTDOWN=2, SPRINT=3, MP=4, PAUSED=5, WON=6, LOST=7; current_screen equals state register.
REQ-013 SHALL latch a mode bit (0 sprint, 1 battle) on leaving START; mode selects the COUNTDOWN exit target.
REQ-014 START: start_sprint -> COUNTDOWN mode 0; else battle_ready -> MP_READY mode 1; start_sprint has priority if both.
REQ-015 MP_READY: all NUM_OPPONENTS opponent_ready bits high in same cycle -> COUNTDOWN; else ready_withdraw -> START.
REQ-016 COUNTDOWN: load countdown_value = COUNTDOWN_CYCLES on entry, decrement each clock; at value 1 go to SPRINT/MP and assert game_start for exactly that transition cycle.
REQ-017 countdown_value SHALL read 0 outside COUNTDOWN.
REQ-018 SPRINT: top_out -> LOST; else lines_cleared >= SPRINT_LINES -> WON; else pause_toggle -> PAUSED.
REQ-019 PAUSED: pause_toggle -> SPRINT; top_out and lines_cleared ignored while paused.
REQ-020 MP: pause_toggle ignored; sticky lost_mask ORs in opponent_lost each cycle; lost_mask cleared on entry to COUNTDOWN.
REQ-021 opponents_alive SHALL equal NUM_OPPONENTS minus popcount(lost_mask); opponent_lost on already-lost bit has no effect.
REQ-022 MP: top_out -> LOST; else lost_mask all-ones (including bits set this cycle) -> WON; top_out wins ties.
REQ-023 game_end SHALL pulse for exactly the cycle of any transition into WON or LOST.
REQ-024 game_won SHALL be 1 in WON, 0 in all other states.
REQ-025 WON/LOST: hold counter loads RESULT_HOLD_CYCLES on entry, decrements to 0; start_sprint or battle_ready -> START only when counter is 0.
REQ-026 randomizer_race SHALL be 1 in START and MP_READY, 0 otherwise.
REQ-027 Combinational outputs SHALL depend only on registered state and current-cycle inputs; no latches.

Reset
REQ-028 rst_l low SHALL asynchronously force state START, mode 0, lost_mask 0, countdown and hold counters 0.
REQ-029 During reset outputs SHALL be current_screen=0, game_start=0, game_end=0, game_won=0, countdown_value=0, opponents_alive=NUM_OPPONENTS, randomizer_race=1.
REQ-030 Reset asserted mid-game or mid-countdown SHALL abandon the session with no game_end pulse.

Verification (NUM_OPPONENTS=3, COUNTDOWN_CYCLES=4, RESULT_HOLD_CYCLES=8, SPRINT_LINES=40)
REQ-031 start_sprint pulse in START -> COUNTDOWN with countdown_value 4,3,2,1, then SPRINT with one game_start pulse 4 clocks after entry.
REQ-032 SPRINT, lines_cleared=39 then 40 -> WON on 40, game_end one cycle, game_won=1; start_sprint at hold count 3 ignored, at 0 -> START.
REQ-033 MP_READY with opponent_ready=3'b011 stays; 3'b111 -> COUNTDOWN; ready_withdraw in MP_READY -> START.
REQ-034 MP: opponent_lost 3'b001, 3'b001, 3'b100 -> opponents_alive 2,2,1; then 3'b010 with top_out same cycle -> LOST, game_won=0.
REQ-035 SPRINT pause_toggle -> PAUSED, top_out ignored, pause_toggle -> SPRINT, lines_cleared=40 -> WON.
REQ-036 rst_l low during MP with opponents_alive=1 -> immediate START, opponents_alive=3, no game_end pulse.

Source files
------------

// File: rtl/game_session_fsm.sv
// -----------------------------------------------------------------------------
// game_session_fsm
//
// Purpose:
//   Session controller for a falling-block game. It handles mode selection
//   (sprint or networked battle), the battle ready handshake, the pre-game
//   countdown, the running game (sprint with pause, or battle with opponent
//   elimination tracking) and the win/lose result screen with a hold-off
//   period before the player may leave it.
//
// Ports:
//   clk              in   system clock
//   rst_l            in   asynchronous active-low reset
//   start_sprint     in   pulse: start a sprint game / leave result screen
//   battle_ready     in   pulse: enter battle ready lobby / leave result screen
//   ready_withdraw   in   pulse: leave the battle lobby
//   pause_toggle     in   pulse: pause / resume a sprint game
//   top_out          in   pulse: local player has topped out
//   lines_cleared    in   local cleared line count
//   opponent_ready   in   per-opponent ready level
//   opponent_lost    in   per-opponent elimination pulse
//   current_screen   out  state code (START=0 .. LOST=7)
//   game_start       out  one-cycle pulse, first cycle of SPRINT/MP
//   game_end         out  one-cycle pulse, first cycle of WON/LOST
//   game_won         out  1 while on the WON screen
//   opponents_alive  out  opponents not yet eliminated
//   countdown_value  out  remaining countdown clocks, 0 outside COUNTDOWN
//   randomizer_race  out  1 while in START or MP_READY
// -----------------------------------------------------------------------------
module game_session_fsm #(
    parameter int NUM_OPPONENTS      = 1,
    parameter int SPRINT_LINES       = 40,
    parameter int LINES_W            = 6,
    parameter int COUNTDOWN_CYCLES   = 4,
    parameter int RESULT_HOLD_CYCLES = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_l,
    input  logic                                     start_sprint,
    input  logic                                     battle_ready,
    input  logic                                     ready_withdraw,
    input  logic                                     pause_toggle,
    input  logic                                     top_out,
    input  logic [LINES_W-1:0]                       lines_cleared,
    input  logic [NUM_OPPONENTS-1:0]                 opponent_ready,
    input  logic [NUM_OPPONENTS-1:0]                 opponent_lost,
    output logic [2:0]                               current_screen,
    output logic                                     game_start,
    output logic                                     game_end,
    output logic                                     game_won,
    output logic [2:0]                               opponents_alive,
    output logic [$clog2(COUNTDOWN_CYCLES+1)-1:0]    countdown_value,
    output logic                                     randomizer_race
);

    localparam int CNT_W  = $clog2(COUNTDOWN_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESULT_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_MP_READY  = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_SPRINT    = 3'd3,
        ST_MP        = 3'd4,
        ST_PAUSED    = 3'd5,
        ST_WON       = 3'd6,
        ST_LOST      = 3'd7
    } state_t;

    state_t                   state_q, state_d;
    logic                     mode_q, mode_d;           // 0 sprint, 1 battle
    logic [NUM_OPPONENTS-1:0] lost_mask_q, lost_mask_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     game_start_q, game_start_d;
    logic                     game_end_q, game_end_d;
    logic [2:0]               lost_count;

    // Next-state and next-register logic
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        lost_mask_d  = lost_mask_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        game_start_d = 1'b0;
        game_end_d   = 1'b0;

        // Hold counter is only non-zero on the result screens; it free-runs
        // down to zero and is reloaded whenever a result screen is entered.
        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        case (state_q)
            ST_START: begin
                if (start_sprint) begin
                    state_d     = ST_COUNTDOWN;
                    mode_d      = 1'b0;
                    cnt_d       = CNT_W'(COUNTDOWN_CYCLES);
                    lost_mask_d = '0;
                end else if (battle_ready) begin
                    state_d = ST_MP_READY;
                    mode_d  = 1'b1;
                end
            end

            ST_MP_READY: begin
                if (&opponent_ready) begin
                    state_d     = ST_COUNTDOWN;
                    cnt_d       = CNT_W'(COUNTDOWN_CYCLES);
                    lost_mask_d = '0;
                end else if (ready_withdraw) begin
                    state_d = ST_START;
                end
            end

            ST_COUNTDOWN: begin
                // Leave on the clock where the counter shows 1; <= guards
                // against ever stalling on a zero count.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d      = mode_q ? ST_MP : ST_SPRINT;
                    cnt_d        = '0;
                    game_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_SPRINT: begin
                if (top_out) begin
                    state_d    = ST_LOST;
                    game_end_d = 1'b1;
                    hold_d     = HOLD_W'(RESULT_HOLD_CYCLES);
                end else if (lines_cleared >= LINES_W'(SPRINT_LINES)) begin
                    state_d    = ST_WON;
                    game_end_d = 1'b1;
                    hold_d     = HOLD_W'(RESULT_HOLD_CYCLES);
                end else if (pause_toggle) begin
                    state_d = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (pause_toggle) begin
                    state_d = ST_SPRINT;
                end
            end

            ST_MP: begin
                // Eliminations arriving this cycle count toward the win check.
                lost_mask_d = lost_mask_q | opponent_lost;
                if (top_out) begin
                    state_d    = ST_LOST;
                    game_end_d = 1'b1;
                    hold_d     = HOLD_W'(RESULT_HOLD_CYCLES);
                end else if (&lost_mask_d) begin
                    state_d    = ST_WON;
                    game_end_d = 1'b1;
                    hold_d     = HOLD_W'(RESULT_HOLD_CYCLES);
                end
            end

            ST_WON, ST_LOST: begin
                if ((hold_q == '0) && (start_sprint || battle_ready)) begin
                    state_d = ST_START;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_START;
            mode_q       <= 1'b0;
            lost_mask_q  <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            game_start_q <= 1'b0;
            game_end_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            lost_mask_q  <= lost_mask_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            game_start_q <= game_start_d;
            game_end_q   <= game_end_d;
        end
    end

    // Number of opponents eliminated so far
    always_comb begin
        lost_count = '0;
        for (int i = 0; i < NUM_OPPONENTS; i++) begin
            lost_count = lost_count + 3'(lost_mask_q[i]);
        end
    end

    assign current_screen  = state_q;
    assign game_start      = game_start_q;
    assign game_end        = game_end_q;
    assign game_won        = (state_q == ST_WON);
    assign opponents_alive = 3'(NUM_OPPONENTS) - lost_count;
    assign countdown_value = cnt_q;
    assign randomizer_race = (state_q == ST_START) || (state_q == ST_MP_READY);

endmodule

// File: tb/tb_game_session_fsm.sv
module tb_game_session_fsm;

    localparam int NOPP = 3;

    logic            clk = 1'b0;
    logic            rst_l = 1'b0;
    logic            start_sprint = 1'b0;
    logic            battle_ready = 1'b0;
    logic            ready_withdraw = 1'b0;
    logic            pause_toggle = 1'b0;
    logic            top_out = 1'b0;
    logic [5:0]      lines_cleared = '0;
    logic [NOPP-1:0] opponent_ready = '0;
    logic [NOPP-1:0] opponent_lost = '0;
    logic [2:0]      current_screen;
    logic            game_start;
    logic            game_end;
    logic            game_won;
    logic [2:0]      opponents_alive;
    logic [2:0]      countdown_value;
    logic            randomizer_race;

    int n_checks = 0;
    int n_pass   = 0;

    game_session_fsm #(
        .NUM_OPPONENTS     (NOPP),
        .SPRINT_LINES      (40),
        .LINES_W           (6),
        .COUNTDOWN_CYCLES  (4),
        .RESULT_HOLD_CYCLES(8)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .start_sprint    (start_sprint),
        .battle_ready    (battle_ready),
        .ready_withdraw  (ready_withdraw),
        .pause_toggle    (pause_toggle),
        .top_out         (top_out),
        .lines_cleared   (lines_cleared),
        .opponent_ready  (opponent_ready),
        .opponent_lost   (opponent_lost),
        .current_screen  (current_screen),
        .game_start      (game_start),
        .game_end        (game_end),
        .game_won        (game_won),
        .opponents_alive (opponents_alive),
        .countdown_value (countdown_value),
        .randomizer_race (randomizer_race)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("check %-22s got %0d expected %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Enter the battle lobby, get everyone ready and run through the countdown
    task automatic enter_mp(input string tag);
        battle_ready = 1'b1; cycle(); battle_ready = 1'b0;
        check({tag, "_lobby"}, current_screen, 1);
        opponent_ready = 3'b111; cycle(); opponent_ready = 3'b000;
        check({tag, "_cd"}, current_screen, 2);
        check({tag, "_alive_reset"}, opponents_alive, 3);
        cycles(4);
        check({tag, "_in_mp"}, current_screen, 4);
        check({tag, "_game_start"}, game_start, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        #2;
        check("rst_screen", current_screen, 0);
        check("rst_game_start", game_start, 0);
        check("rst_game_end", game_end, 0);
        check("rst_game_won", game_won, 0);
        check("rst_countdown", countdown_value, 0);
        check("rst_alive", opponents_alive, 3);
        check("rst_race", randomizer_race, 1);
        #10 rst_l = 1'b1;
        cycle();
        check("idle_screen", current_screen, 0);

        // ---------------- sprint countdown ----------------
        start_sprint = 1'b1; cycle(); start_sprint = 1'b0;
        check("cd_screen", current_screen, 2);
        check("cd_race", randomizer_race, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cd_value_%0d", k), countdown_value, 4 - k);
            check($sformatf("cd_no_start_%0d", k), game_start, 0);
            cycle();
        end
        check("sprint_screen", current_screen, 3);
        check("sprint_game_start", game_start, 1);
        check("sprint_cd_zero", countdown_value, 0);
        cycle();
        check("sprint_start_once", game_start, 0);

        // ---------------- pause handling ----------------
        pause_toggle = 1'b1; cycle(); pause_toggle = 1'b0;
        check("paused_screen", current_screen, 5);
        top_out = 1'b1; lines_cleared = 6'd40; cycle();
        top_out = 1'b0; lines_cleared = 6'd0;
        check("paused_ignores", current_screen, 5);
        check("paused_no_end", game_end, 0);
        pause_toggle = 1'b1; cycle(); pause_toggle = 1'b0;
        check("resumed_screen", current_screen, 3);

        // ---------------- sprint win at line target ----------------
        lines_cleared = 6'd39; cycle();
        check("lines39_screen", current_screen, 3);
        check("lines39_no_end", game_end, 0);
        lines_cleared = 6'd40; cycle(); lines_cleared = 6'd0;
        check("won_screen", current_screen, 6);
        check("won_game_end", game_end, 1);
        check("won_game_won", game_won, 1);
        cycle();                                    // hold = 7
        check("won_end_once", game_end, 0);
        cycles(4);                                  // hold = 3
        start_sprint = 1'b1; cycle(); start_sprint = 1'b0;
        check("hold3_ignored", current_screen, 6);
        cycle();                                    // hold = 1
        start_sprint = 1'b1; cycle(); start_sprint = 1'b0;
        check("hold1_ignored", current_screen, 6);
        start_sprint = 1'b1; cycle(); start_sprint = 1'b0;
        check("hold0_exit", current_screen, 0);
        check("exit_game_won", game_won, 0);
        check("exit_race", randomizer_race, 1);

        // ---------------- battle lobby ----------------
        battle_ready = 1'b1; cycle(); battle_ready = 1'b0;
        check("lobby_screen", current_screen, 1);
        check("lobby_race", randomizer_race, 1);
        opponent_ready = 3'b011; cycle();
        check("lobby_partial", current_screen, 1);
        opponent_ready = 3'b000;
        ready_withdraw = 1'b1; cycle(); ready_withdraw = 1'b0;
        check("lobby_withdraw", current_screen, 0);

        // ---------------- battle loss with eliminations ----------------
        enter_mp("mp1");
        opponent_lost = 3'b001; cycle();
        check("mp1_alive_a", opponents_alive, 2);
        opponent_lost = 3'b001; pause_toggle = 1'b1; cycle(); pause_toggle = 1'b0;
        check("mp1_alive_b", opponents_alive, 2);
        check("mp1_pause_ign", current_screen, 4);
        opponent_lost = 3'b100; cycle();
        check("mp1_alive_c", opponents_alive, 1);
        opponent_lost = 3'b010; top_out = 1'b1; cycle();
        opponent_lost = 3'b000; top_out = 1'b0;
        check("mp1_lost_screen", current_screen, 7);
        check("mp1_lost_end", game_end, 1);
        check("mp1_lost_won", game_won, 0);
        check("mp1_lost_alive", opponents_alive, 0);
        cycles(8);                                  // hold reaches 0
        battle_ready = 1'b1; cycle(); battle_ready = 1'b0;
        check("mp1_exit", current_screen, 0);

        // ---------------- reset mid-battle ----------------
        enter_mp("mp2");
        opponent_lost = 3'b011; cycle(); opponent_lost = 3'b000;
        check("mp2_alive", opponents_alive, 1);
        #2 rst_l = 1'b0;
        #1;
        check("arst_screen", current_screen, 0);
        check("arst_alive", opponents_alive, 3);
        check("arst_no_end", game_end, 0);
        check("arst_race", randomizer_race, 1);
        #10 rst_l = 1'b1;
        cycle();
        check("post_rst_screen", current_screen, 0);
        check("post_rst_no_end", game_end, 0);

        // ---------------- battle win, last eliminations same cycle ----------------
        enter_mp("mp3");
        opponent_lost = 3'b110; cycle();
        check("mp3_alive", opponents_alive, 1);
        check("mp3_still_mp", current_screen, 4);
        opponent_lost = 3'b001; cycle(); opponent_lost = 3'b000;
        check("mp3_won_screen", current_screen, 6);
        check("mp3_won_end", game_end, 1);
        check("mp3_won_flag", game_won, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
